// File: rtl/route_request_unit.sv
// Route request unit: flit FIFO, routing-table lookup, switch-allocator request.
// Optional macro ROUTE_DIR_CHECK_EN drops flits whose looked-up direction exceeds 4.
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif
`ifndef BITS_DIR
`define BITS_DIR 3
`endif

module route_request_unit #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [FLIT_W-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [`ADDR_SZ-1:0]  table_addr,
    input  logic [`BITS_DIR-1:0] table_data,
    output logic                 req_valid,
    output logic [`BITS_DIR-1:0] req_dir,
    output logic [FLIT_W-1:0]    req_data,
    input  logic                 req_grant,
    output logic                 route_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIR_W = `BITS_DIR;

    typedef enum logic [1:0] {IDLE, LOOKUP, REQUEST} state_t;

    state_t             r_state, w_next;
    logic [FLIT_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr, r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_req_valid, r_route_err;
    logic [DIR_W-1:0]   r_req_dir;
    logic               w_push, w_pop, w_latch, w_bad_dir;

`ifdef ROUTE_DIR_CHECK_EN
    assign w_bad_dir = (table_data > DIR_W'(4));
`else
    assign w_bad_dir = 1'b0;
`endif

    assign in_ready   = (r_count != CNT_W'(DEPTH));
    assign w_push     = in_valid && in_ready;
    assign table_addr = r_mem[r_rptr][`ADDR_SZ-1:0];
    assign req_data   = r_mem[r_rptr];
    assign req_valid  = r_req_valid;
    assign req_dir    = r_req_dir;
    assign route_err  = r_route_err;

    always_comb begin
        w_next  = r_state;
        w_pop   = 1'b0;
        w_latch = 1'b0;
        case (r_state)
            IDLE:    if (r_count != '0) w_next = LOOKUP;
            LOOKUP: begin
                if (w_bad_dir) begin
                    w_pop  = 1'b1;
                    w_next = IDLE;
                end else begin
                    w_latch = 1'b1;
                    w_next  = REQUEST;
                end
            end
            REQUEST: begin
                if (req_grant) begin
                    w_pop  = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_req_valid <= 1'b0;
            r_req_dir   <= '0;
            r_route_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            // valid tracks the next state so it is a flop, never a grant-to-valid path
            r_req_valid <= (w_next == REQUEST);
            r_route_err <= (r_state == LOOKUP) && w_bad_dir;
            if (w_latch) r_req_dir <= table_data;
            if (w_push)  r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)   r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) r_mem[r_wptr] <= in_data;
    end

endmodule

// File: doc/route_request_unit.md
ROUTE_REQUEST_UNIT -- requirements
Module: route_request_unit

Interface
REQ-001 Parameter FLIT_W, default 32: flit width in bits; destination node address in bits [`ADDR_SZ-1:0].
REQ-002 Parameter DEPTH, default 4: input FIFO depth in flits; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  FLIT_W  flit from upstream link.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  FIFO can accept a flit this cycle.
REQ-008 table_addr  output  `ADDR_SZ  destination address presented to the routing table.
REQ-009 table_data  input  `BITS_DIR  combinational direction returned by the routing table (0-3 mesh ports, 4 local).
REQ-010 req_valid  output  1  request to the switch allocator pending.
REQ-011 req_dir  output  `BITS_DIR  requested output direction.
REQ-012 req_data  output  FLIT_W  flit at FIFO head.
REQ-013 req_grant  input  1  allocator grant; flit leaves on this cycle.
REQ-014 route_err  output  1  one-cycle pulse: flit dropped for an illegal direction.

Function
REQ-015 Flit pushed at rising edge when in_valid && in_ready; in_ready = (count != DEPTH), independent of req_grant.
REQ-016 FIFO: circular buffer, read/write pointers wrap from DEPTH-1 to 0; count range 0..DEPTH.
REQ-017 Push and pop on the same edge leave count unchanged; push with count==DEPTH impossible by REQ-015.
REQ-018 table_addr = head flit bits [`ADDR_SZ-1:0], driven continuously from the FIFO head.
REQ-019 FSM states IDLE, LOOKUP, REQUEST; IDLE -> LOOKUP when count>0.
REQ-020 LOOKUP: latch table_data into req_dir register; -> REQUEST (or per REQ-033).
REQ-021 REQUEST: req_valid=1, req_dir=latched value, req_data=head flit; all held stable until grant.
REQ-022 On req_grant sampled high in REQUEST: pop head, -> IDLE; req_valid low next cycle.
REQ-023 req_grant ignored in IDLE and LOOKUP.
REQ-024 Latency: flit accepted at edge E0 into empty FIFO -> LOOKUP at E1, req_valid high from E2.
REQ-025 Back-to-back: after pop at Eg with count still >0, LOOKUP at Eg+1, req_valid high from Eg+2.
REQ-026 req_valid, route_err are registered outputs; no combinational path from req_grant to req_valid.

Reset
REQ-027 On reset high at a rising edge: state IDLE, pointers and count 0, all FIFO contents discarded.
REQ-028 Reset values: in_ready=1 after reset edge, req_valid=0, req_dir=0, route_err=0; req_data don't-care.
REQ-029 Reset mid-operation (any state, any count) overrides push, pop and grant on that edge.
REQ-030 In-flight request abandoned on reset; grant in the reset cycle produces no pop.

Configuration
REQ-031 Macro ROUTE_DIR_CHECK_EN enables illegal-direction checking.
REQ-032 Without ROUTE_DIR_CHECK_EN: route_err tied 0; any table_data value latched and requested.
REQ-033 With ROUTE_DIR_CHECK_EN: in LOOKUP, table_data > 4 pops head, pulses route_err for one cycle, -> IDLE; no request issued.

Verification
REQ-034 Reset, push dst=4 with table model node 0 (4->2) -> req_valid at E2, req_dir=2, req_data=flit.
REQ-035 Fill 4 flits with req_grant=0 -> in_ready=0 after 4th push; 5th in_valid not accepted; grant drains in order 0,1,2,3.
REQ-036 Grant held high continuously, 6 flits pushed at full rate -> one flit per 3 cycles out, pointers wrap, no loss or reorder.
REQ-037 Push and grant on the same edge with count=2 -> count stays 2, correct head advance.
REQ-038 Assert reset while in REQUEST with count=3 -> req_valid=0, in_ready=1 next cycle; subsequent flit served from empty state.
REQ-039 With ROUTE_DIR_CHECK_EN, table model returns 7 -> route_err single pulse, flit dropped, next flit routed normally; without macro -> req_dir=7.
